// File: rtl/clk_rst_pkg.sv
// Shared types and default parameters for the DUT-side reset controller.
package clk_rst_pkg;

   typedef enum logic [1:0] {
      RST_ASSERT = 2'd0,
      RST_HOLD   = 2'd1,
      RST_RUN    = 2'd2,
      RST_SWRST  = 2'd3
   } rst_state_e;

   localparam int unsigned DEF_SYNC_STAGES   = 2;
   localparam int unsigned DEF_HOLD_CYCLES   = 8;
   localparam int unsigned DEF_SW_RST_CYCLES = 4;
   localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert, sync-deassert reset release synchronizer.
module rst_sync_chain #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_sync_rel
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign o_sync_rel = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clk_rst_sync_ctrl.sv
// Core reset controller: synchronized, stretched release of an active-low core reset,
// plus software-requested resets with a saturating event counter.
module clk_rst_sync_ctrl
   import clk_rst_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int unsigned SW_RST_CYCLES = DEF_SW_RST_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sw_rst_req,
   output logic             rst_out_n,
   output logic             rst_done,
   output logic [CNT_W-1:0] sw_rst_cnt,
   output logic [1:0]       state_o
);

   localparam int unsigned MAX_CYC = (HOLD_CYCLES > SW_RST_CYCLES) ? HOLD_CYCLES : SW_RST_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]    SW_LAST   = CW'(SW_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SW_MAX    = {CNT_W{1'b1}};

   rst_state_e       r_state, w_state_d;
   logic [CW-1:0]    r_cnt, w_cnt_d;
   logic             r_rst_out_n, w_rst_out_n_d;
   logic             r_rst_done, w_rst_done_d;
   logic [CNT_W-1:0] r_sw_cnt, w_sw_cnt_d;
   logic             w_sync_rel;

   rst_sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clk     (clk),
      .i_reset   (reset),
      .o_sync_rel(w_sync_rel)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RST_ASSERT;
         r_cnt       <= '0;
         r_rst_out_n <= 1'b0;
         r_rst_done  <= 1'b0;
         r_sw_cnt    <= '0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_rst_out_n <= w_rst_out_n_d;
         r_rst_done  <= w_rst_done_d;
         r_sw_cnt    <= w_sw_cnt_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = '0;
      unique case (r_state)
         RST_ASSERT: begin
            if (w_sync_rel) w_state_d = RST_HOLD;
         end
         RST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_d = RST_RUN;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         RST_RUN: begin
            if (sw_rst_req) w_state_d = RST_SWRST;
         end
         RST_SWRST: begin
            if (r_cnt == SW_LAST) begin
               w_state_d = RST_HOLD;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         default: w_state_d = RST_ASSERT;
      endcase
   end

   // Output flops are loaded from the next state so rst_out_n rises on the RUN-entry edge.
   always_comb begin
      w_rst_out_n_d = (w_state_d == RST_RUN);
      w_rst_done_d  = (w_state_d == RST_RUN) && (r_state != RST_RUN);
      w_sw_cnt_d    = r_sw_cnt;
      if ((r_state == RST_RUN) && sw_rst_req && (r_sw_cnt != SW_MAX)) begin
         w_sw_cnt_d = r_sw_cnt + CNT_W'(1);
      end
   end

   assign rst_out_n  = r_rst_out_n;
   assign rst_done   = r_rst_done;
   assign sw_rst_cnt = r_sw_cnt;
   assign state_o    = r_state;

endmodule

// File: tb/tb_clk_rst_sync_ctrl.sv
// Directed bench for clk_rst_sync_ctrl: power-on, software resets, mid-run reset, glitch.
module tb_clk_rst_sync_ctrl;

   logic       clk;
   logic       reset;
   logic       sw_rst_req;
   logic       rst_out_n, rst_done;
   logic [7:0] sw_rst_cnt;
   logic [1:0] state_o;
   logic       rst_out_n2, rst_done2;
   logic [1:0] sw_rst_cnt2;
   logic [1:0] state_o2;

   int n_tests = 0;
   int n_fail  = 0;

   clk_rst_sync_ctrl u_dut (
      .clk       (clk),
      .reset     (reset),
      .sw_rst_req(sw_rst_req),
      .rst_out_n (rst_out_n),
      .rst_done  (rst_done),
      .sw_rst_cnt(sw_rst_cnt),
      .state_o   (state_o)
   );

   clk_rst_sync_ctrl #(
      .CNT_W(2)
   ) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .sw_rst_req(sw_rst_req),
      .rst_out_n (rst_out_n2),
      .rst_done  (rst_done2),
      .sw_rst_cnt(sw_rst_cnt2),
      .state_o   (state_o2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      n_tests++;
      if (obs !== expd) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expd, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Caller releases reset between edges; next posedge is edge 1.
   task automatic powerup_check();
      for (int k = 1; k <= 10; k++) begin
         step();
         check_eq("por_rst_out_n_low", {31'd0, rst_out_n}, 32'd0);
         check_eq("por_done_low", {31'd0, rst_done}, 32'd0);
         if (k == 2) check_eq("por_state_assert_e2", {30'd0, state_o}, 32'd0);
         if (k == 3) check_eq("por_state_hold_e3", {30'd0, state_o}, 32'd1);
      end
      step();
      check_eq("por_rst_out_n_e11", {31'd0, rst_out_n}, 32'd1);
      check_eq("por_done_e11", {31'd0, rst_done}, 32'd1);
      check_eq("por_state_run", {30'd0, state_o}, 32'd2);
      check_eq("por_cnt_zero", {24'd0, sw_rst_cnt}, 32'd0);
      check_eq("por_cnt2_zero", {30'd0, sw_rst_cnt2}, 32'd0);
      check_eq("por_dut2_out", {31'd0, rst_out_n2}, 32'd1);
      step();
      check_eq("por_done_e12", {31'd0, rst_done}, 32'd0);
      check_eq("por_rst_out_n_e12", {31'd0, rst_out_n}, 32'd1);
   endtask

   // 11 further low edges after the trigger edge, then release with rst_done.
   task automatic wait_release();
      for (int k = 1; k <= 11; k++) begin
         step();
         check_eq("sw_low_window", {31'd0, rst_out_n}, 32'd0);
         check_eq("sw_done_low", {31'd0, rst_done}, 32'd0);
      end
      step();
      check_eq("sw_release", {31'd0, rst_out_n}, 32'd1);
      check_eq("sw_release_done", {31'd0, rst_done}, 32'd1);
      check_eq("sw_release_state", {30'd0, state_o}, 32'd2);
   endtask

   task automatic sw_pulse(input int exp_cnt, input int exp_cnt2);
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      check_eq("sw_trig_out", {31'd0, rst_out_n}, 32'd0);
      check_eq("sw_trig_state", {30'd0, state_o}, 32'd3);
      check_eq("sw_cnt", {24'd0, sw_rst_cnt}, exp_cnt);
      check_eq("sw_cnt2", {30'd0, sw_rst_cnt2}, exp_cnt2);
      wait_release();
      step();
      check_eq("sw_done_clear", {31'd0, rst_done}, 32'd0);
   endtask

   initial begin
      reset      = 1'b0;
      sw_rst_req = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_eq("rst_out_n_in_reset", {31'd0, rst_out_n}, 32'd0);
      check_eq("state_in_reset", {30'd0, state_o}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("hold_rst_out_n", {31'd0, rst_out_n}, 32'd0);
         check_eq("hold_done", {31'd0, rst_done}, 32'd0);
         check_eq("hold_cnt", {24'd0, sw_rst_cnt}, 32'd0);
         check_eq("hold_state", {30'd0, state_o}, 32'd0);
      end
      #3 reset = 1'b0;
      powerup_check();

      // Single pulse, then held request re-triggering after one RUN cycle.
      sw_pulse(1, 1);
      sw_rst_req = 1'b1;
      step();
      check_eq("held_cnt_a", {24'd0, sw_rst_cnt}, 32'd2);
      check_eq("held_cnt2_a", {30'd0, sw_rst_cnt2}, 32'd2);
      wait_release();
      check_eq("held_cnt_at_run", {24'd0, sw_rst_cnt}, 32'd2);
      step();
      check_eq("held_retrig_state", {30'd0, state_o}, 32'd3);
      check_eq("held_retrig_out", {31'd0, rst_out_n}, 32'd0);
      check_eq("held_cnt_b", {24'd0, sw_rst_cnt}, 32'd3);
      check_eq("held_cnt2_b", {30'd0, sw_rst_cnt2}, 32'd3);
      sw_rst_req = 1'b0;
      wait_release();
      step();
      check_eq("held_done_clear", {31'd0, rst_done}, 32'd0);
      sw_pulse(4, 3);
      sw_pulse(5, 3);

      // Hardware reset between edges while in SWRST.
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      step();
      step();
      check_eq("mid_swrst_state", {30'd0, state_o}, 32'd3);
      #3 reset = 1'b1;
      #1;
      check_eq("async_out", {31'd0, rst_out_n}, 32'd0);
      check_eq("async_cnt", {24'd0, sw_rst_cnt}, 32'd0);
      check_eq("async_cnt2", {30'd0, sw_rst_cnt2}, 32'd0);
      check_eq("async_state", {30'd0, state_o}, 32'd0);
      #1 reset = 1'b0;
      powerup_check();

      // 3 ns glitch from RUN.
      #1 reset = 1'b1;
      #1;
      check_eq("glitch_out", {31'd0, rst_out_n}, 32'd0);
      check_eq("glitch_state", {30'd0, state_o}, 32'd0);
      #2 reset = 1'b0;
      powerup_check();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
